// File: rtl/i_fetch.sv
// RV32I instruction-fetch stage: owns the PC, drives the I-cache read handshake and registers the IF/ID bundle.
// Optional RVFI trace fields in if_out.rvfi_d are enabled by defining I_FETCH_RVFI_EN.
package i_fetch_pkg;
  typedef struct packed {
    logic [31:0] word;
  } instr_t;

  typedef struct packed {
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_pc_wdata;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
  } rvfi_t;

  typedef struct packed {
    logic [31:0] pc;
    instr_t      ir;
    logic        valid;
    rvfi_t       rvfi_d;
  } IF_ID_stage_t;
endpackage

module i_fetch
  import i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         branch_take,
  input  logic [31:0]  branch_target,
  output logic [31:0]  imem_address,
  output logic         imem_read,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_resp,
  output IF_ID_stage_t if_out
);

  typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_e;

  state_e       state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_buf_q, hold_buf_d;
  logic [31:0]  pend_target_q, pend_target_d;
  IF_ID_stage_t if_out_q, if_out_d;

  function automatic IF_ID_stage_t bubble(input logic [31:0] pc);
    IF_ID_stage_t b;
    b         = '0;
    b.pc      = pc;
    b.ir.word = NOP_WORD;
    return b;
  endfunction

  function automatic IF_ID_stage_t fetched(input logic [31:0] pc, input logic [31:0] word);
    IF_ID_stage_t f;
    f         = '0;
    f.pc      = pc;
    f.ir.word = word;
    f.valid   = 1'b1;
`ifdef I_FETCH_RVFI_EN
    f.rvfi_d.rvfi_valid    = 1'b1;
    f.rvfi_d.rvfi_pc_rdata = pc;
    f.rvfi_d.rvfi_pc_wdata = pc + 32'd4;
`endif
    return f;
  endfunction

  // The request depends only on registered state, so no resp/stall path reaches the cache.
  assign imem_read    = (state_q != HOLD);
  assign imem_address = pc_q;
  assign if_out       = if_out_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    pc_d          = pc_q;
    hold_buf_d    = hold_buf_q;
    pend_target_d = pend_target_q;
    if_out_d      = if_out_q;

    case (state_q)
      RUN: begin
        if (branch_take) begin
          if_out_d = bubble(pc_q);
          if (imem_resp) begin
            pc_d = branch_target;
          end else begin
            // Keep the outstanding address stable until the cache answers.
            pend_target_d = branch_target;
            state_d       = DRAIN;
          end
        end else if (imem_resp) begin
          if (!stall_i) begin
            if_out_d = fetched(pc_q, imem_rdata);
            pc_d     = pc_q + 32'd4;
          end else begin
            hold_buf_d = imem_rdata;
            state_d    = HOLD;
          end
        end else if (!stall_i) begin
          if_out_d = bubble(pc_q);
        end
      end

      HOLD: begin
        if (branch_take) begin
          if_out_d = bubble(pc_q);
          pc_d     = branch_target;
          state_d  = RUN;
        end else if (!stall_i) begin
          if_out_d = fetched(pc_q, hold_buf_q);
          pc_d     = pc_q + 32'd4;
          state_d  = RUN;
        end
      end

      DRAIN: begin
        if_out_d = bubble(pc_q);
        if (imem_resp) begin
          pc_d    = branch_take ? branch_target : pend_target_q;
          state_d = RUN;
        end else if (branch_take) begin
          pend_target_d = branch_target;
        end
      end

      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      hold_buf_q    <= '0;
      pend_target_q <= '0;
      if_out_q      <= bubble(RESET_PC);
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_buf_q    <= hold_buf_d;
      pend_target_q <= pend_target_d;
      if_out_q      <= if_out_d;
    end
  end

endmodule

// File: tb/tb_i_fetch.sv
// Testbench for i_fetch: directed scenarios plus randomized cache/hazard traffic against a transaction-level model.
module tb_i_fetch;
  import i_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall_i;
  logic         branch_take;
  logic [31:0]  branch_target;
  logic [31:0]  imem_address;
  logic         imem_read;
  logic [31:0]  imem_rdata;
  logic         imem_resp;
  IF_ID_stage_t if_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: current PC, at most one word parked by a stall, at most one redirect awaiting a stale response.
  logic [31:0]  m_pc;
  IF_ID_stage_t m_out;
  logic [31:0]  m_held[$];
  logic [31:0]  m_redir[$];

  i_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .branch_take  (branch_take),
    .branch_target(branch_target),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .if_out       (if_out)
  );

  always #5 clk = ~clk;

  function automatic IF_ID_stage_t exp_bubble(input logic [31:0] pc);
    IF_ID_stage_t b;
    b = '0;
    b.pc = pc;
    b.ir.word = NOP_WORD;
    return b;
  endfunction

  function automatic IF_ID_stage_t exp_word(input logic [31:0] pc, input logic [31:0] w);
    IF_ID_stage_t f;
    f = '0;
    f.pc = pc;
    f.ir.word = w;
    f.valid = 1'b1;
`ifdef I_FETCH_RVFI_EN
    f.rvfi_d.rvfi_valid = 1'b1;
    f.rvfi_d.rvfi_pc_rdata = pc;
    f.rvfi_d.rvfi_pc_wdata = pc + 32'd4;
`endif
    return f;
  endfunction

  task automatic model_reset();
    m_pc  = RESET_PC;
    m_out = exp_bubble(RESET_PC);
    m_held.delete();
    m_redir.delete();
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, and settle just after the edge.
  task automatic step(input logic s, input logic b, input logic [31:0] t,
                      input logic r, input logic [31:0] d);
    stall_i = s; branch_take = b; branch_target = t; imem_resp = r; imem_rdata = d;
    if (m_held.size() != 0) begin
      if (b) begin
        m_out = exp_bubble(m_pc); m_pc = t; m_held.delete();
      end else if (!s) begin
        m_out = exp_word(m_pc, m_held[0]); m_pc = m_pc + 32'd4; m_held.delete();
      end
    end else if (m_redir.size() != 0) begin
      m_out = exp_bubble(m_pc);
      if (r) begin
        m_pc = b ? t : m_redir[0]; m_redir.delete();
      end else if (b) begin
        m_redir[0] = t;
      end
    end else if (b) begin
      m_out = exp_bubble(m_pc);
      if (r) m_pc = t;
      else m_redir.push_back(t);
    end else if (r) begin
      if (!s) begin
        m_out = exp_word(m_pc, d); m_pc = m_pc + 32'd4;
      end else begin
        m_held.push_back(d);
      end
    end else if (!s) begin
      m_out = exp_bubble(m_pc);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall_i = 1'b0; branch_take = 1'b0; branch_target = '0; imem_resp = 1'b0; imem_rdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (if_out !== exp_bubble(RESET_PC)) $display("FAIL reset_if_out got=%h want=%h", if_out, exp_bubble(RESET_PC)); else n_pass++;
    n_checks++; if (imem_read !== 1'b1) $display("FAIL reset_imem_read got=%b want=1", imem_read); else n_pass++;
    n_checks++; if (imem_address !== RESET_PC) $display("FAIL reset_imem_address got=%h want=%h", imem_address, RESET_PC); else n_pass++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = RESET_PC + 32'(4 * i);
      step(1'b0, 1'b0, '0, 1'b1, imem_address ^ 32'hA5A5_0000);
      n_checks++; if (if_out !== exp_word(a, a ^ 32'hA5A5_0000)) $display("FAIL zero_wait_%0d got pc=%h ir=%h v=%b want pc=%h ir=%h v=1", i, if_out.pc, if_out.ir.word, if_out.valid, a, a ^ 32'hA5A5_0000); else n_pass++;
    end
  endtask

  task automatic test_miss();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b0, '0);
      n_checks++; if (if_out.valid !== 1'b0 || if_out.ir.word !== NOP_WORD) $display("FAIL miss_bubble_%0d got ir=%h v=%b want ir=%h v=0", i, if_out.ir.word, if_out.valid, NOP_WORD); else n_pass++;
    end
    step(1'b0, 1'b0, '0, 1'b1, 32'h1234_5678);
    n_checks++; if (if_out !== exp_word(RESET_PC, 32'h1234_5678)) $display("FAIL miss_word got pc=%h ir=%h v=%b want pc=%h ir=12345678 v=1", if_out.pc, if_out.ir.word, if_out.valid, RESET_PC); else n_pass++;
  endtask

  task automatic test_stall_hold();
    do_reset();
    step(1'b1, 1'b0, '0, 1'b1, 32'hCAFE_0001);
    n_checks++; if (imem_read !== 1'b0) $display("FAIL hold_read_1 got=%b want=0", imem_read); else n_pass++;
    n_checks++; if (if_out !== exp_bubble(RESET_PC)) $display("FAIL hold_if_out_1 got=%h want=%h", if_out, exp_bubble(RESET_PC)); else n_pass++;
    step(1'b1, 1'b0, '0, 1'b0, '0);
    n_checks++; if (imem_read !== 1'b0) $display("FAIL hold_read_2 got=%b want=0", imem_read); else n_pass++;
    n_checks++; if (if_out !== exp_bubble(RESET_PC)) $display("FAIL hold_if_out_2 got=%h want=%h", if_out, exp_bubble(RESET_PC)); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b0, '0);
    n_checks++; if (if_out !== exp_word(RESET_PC, 32'hCAFE_0001)) $display("FAIL hold_release got pc=%h ir=%h v=%b want pc=%h ir=cafe0001 v=1", if_out.pc, if_out.ir.word, if_out.valid, RESET_PC); else n_pass++;
    n_checks++; if (imem_read !== 1'b1 || imem_address !== 32'h4000_0004) $display("FAIL hold_next_addr got rd=%b addr=%h want rd=1 addr=40000004", imem_read, imem_address); else n_pass++;
  endtask

  task automatic test_branch_drain();
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1, 32'h0000_1111);
    step(1'b0, 1'b0, '0, 1'b1, 32'h0000_2222);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h4000_0100, 1'b0, '0);
    n_checks++; if (imem_address !== 32'h4000_0008 || imem_read !== 1'b1) $display("FAIL drain_addr_1 got rd=%b addr=%h want rd=1 addr=40000008", imem_read, imem_address); else n_pass++;
    n_checks++; if (if_out.valid !== 1'b0) $display("FAIL drain_bubble_1 got v=%b want v=0", if_out.valid); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b0, '0);
    n_checks++; if (imem_address !== 32'h4000_0008) $display("FAIL drain_addr_2 got=%h want=40000008", imem_address); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
    n_checks++; if (if_out !== exp_bubble(32'h4000_0008)) $display("FAIL drain_discard got pc=%h ir=%h v=%b want bubble pc=40000008", if_out.pc, if_out.ir.word, if_out.valid); else n_pass++;
    n_checks++; if (imem_address !== 32'h4000_0100) $display("FAIL drain_redirect got=%h want=40000100", imem_address); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b1, 32'h0BAD_F00D);
    n_checks++; if (if_out !== exp_word(32'h4000_0100, 32'h0BAD_F00D)) $display("FAIL drain_target_word got pc=%h ir=%h v=%b want pc=40000100 ir=0badf00d v=1", if_out.pc, if_out.ir.word, if_out.valid); else n_pass++;
  endtask

  task automatic test_back_to_back_redirect();
    do_reset();
    step(1'b0, 1'b1, 32'h4000_0100, 1'b0, '0);
    step(1'b0, 1'b1, 32'h4000_0200, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h7777_7777);
    n_checks++; if (imem_address !== 32'h4000_0200) $display("FAIL chain_target got=%h want=40000200", imem_address); else n_pass++;
    n_checks++; if (if_out.valid !== 1'b0) $display("FAIL chain_bubble got v=%b want v=0", if_out.valid); else n_pass++;
    step(1'b1, 1'b0, '0, 1'b1, 32'h5555_AAAA);
    n_checks++; if (imem_read !== 1'b0) $display("FAIL chain_hold_read got=%b want=0", imem_read); else n_pass++;
    step(1'b1, 1'b1, 32'h4000_0300, 1'b0, '0);
    n_checks++; if (if_out !== exp_bubble(32'h4000_0200)) $display("FAIL chain_hold_branch got pc=%h ir=%h v=%b want bubble pc=40000200", if_out.pc, if_out.ir.word, if_out.valid); else n_pass++;
    n_checks++; if (imem_read !== 1'b1 || imem_address !== 32'h4000_0300) $display("FAIL chain_hold_redirect got rd=%b addr=%h want rd=1 addr=40000300", imem_read, imem_address); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
    n_checks++; if (imem_address !== 32'hFFFF_FFFC) $display("FAIL wrap_addr_before got=%h want=fffffffc", imem_address); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b1, 32'h0000_0513);
    n_checks++; if (if_out.pc !== 32'hFFFF_FFFC || if_out.valid !== 1'b1) $display("FAIL wrap_word got pc=%h v=%b want pc=fffffffc v=1", if_out.pc, if_out.valid); else n_pass++;
    n_checks++; if (imem_address !== 32'h0000_0000) $display("FAIL wrap_addr_after got=%h want=00000000", imem_address); else n_pass++;
`ifdef I_FETCH_RVFI_EN
    n_checks++; if (if_out.rvfi_d.rvfi_pc_wdata !== 32'h0 || if_out.rvfi_d.rvfi_pc_rdata !== 32'hFFFF_FFFC || if_out.rvfi_d.rvfi_valid !== 1'b1) $display("FAIL wrap_rvfi got rd=%h wd=%h v=%b want rd=fffffffc wd=00000000 v=1", if_out.rvfi_d.rvfi_pc_rdata, if_out.rvfi_d.rvfi_pc_wdata, if_out.rvfi_d.rvfi_valid); else n_pass++;
`else
    n_checks++; if (if_out.rvfi_d !== '0) $display("FAIL wrap_rvfi_tied got=%h want=0", if_out.rvfi_d); else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic s, b, r;
    logic [31:0] t, d;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_checks++; if (imem_read !== (m_held.size() == 0)) $display("FAIL rand_read cyc=%0d got=%b want=%b", cyc, imem_read, m_held.size() == 0); else n_pass++;
      if (m_held.size() == 0) begin
        n_checks++; if (imem_address !== m_pc) $display("FAIL rand_addr cyc=%0d got=%h want=%h", cyc, imem_address, m_pc); else n_pass++;
      end
      s = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 9) == 0);
      t = $urandom;
      r = (m_held.size() == 0) && ($urandom_range(0, 1) == 1);
      d = $urandom;
      step(s, b, t, r, d);
      n_checks++; if (if_out !== m_out) $display("FAIL rand_if_out cyc=%0d got pc=%h ir=%h v=%b want pc=%h ir=%h v=%b", cyc, if_out.pc, if_out.ir.word, if_out.valid, m_out.pc, m_out.ir.word, m_out.valid); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 1'b0; branch_take = 1'b0; branch_target = '0; imem_resp = 1'b0; imem_rdata = '0;
    test_reset();
    test_zero_wait();
    test_miss();
    test_stall_hold();
    test_branch_drain();
    test_back_to_back_redirect();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i_fetch.md
# i_fetch

Instruction-fetch stage of the five-stage RV32I pipeline. Owns the program counter and drives the instruction-memory (I-cache) read handshake. Registers each fetched word into the IF/ID bundle consumed by `i_decode`. Handles stalls from the hazard unit and redirects from resolved branches/jumps, including a redirect that arrives while an I-cache read is still outstanding.

## Interface
Parameters:
- `RESET_PC`, default 32'h4000_0000: PC fetched first after reset.
- `NOP_WORD`, default 32'h0000_0013: instruction word used for bubbles (`addi x0,x0,0`).

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_i`  in  1  hazard unit: hold `if_out` and PC this cycle.
- `branch_take`  in  1  redirect request from EX; same signal that flushes `i_decode`.
- `branch_target`  in  32  redirect PC, valid when `branch_take`=1.
- `imem_address`  out  32  I-cache address.
- `imem_read`  out  1  I-cache read request.
- `imem_rdata`  in  32  I-cache data, valid when `imem_resp`=1.
- `imem_resp`  in  1  I-cache response; may arrive in the same cycle as the request.
- `if_out`  out  `IF_ID_stage_t`  registered bundle to ID: `pc`, `ir.word`, `valid`, `rvfi_d`.

## Operation
- Internal registers: `pc`, `state` ∈ {RUN, HOLD, DRAIN}, `hold_buf` (32), `pend_target` (32).
- Bubble = {`pc`=current pc, `ir.word`=NOP_WORD, `valid`=0, `rvfi_d`='0}.
- Priority in every state: `branch_take` > `imem_resp` > `stall_i`.
- RUN: `imem_read`=1, `imem_address`=`pc`.
  - `branch_take` & `imem_resp`: discard rdata; `pc`<=`branch_target`; `if_out`<=bubble; stay RUN.
  - `branch_take` & !`imem_resp`: `pend_target`<=`branch_target`; `if_out`<=bubble; go DRAIN. `pc` is unchanged so the address stays stable.
  - `imem_resp` & !`stall_i`: `if_out`<={`pc`, `imem_rdata`, valid=1}; `pc`<=`pc`+4.
  - `imem_resp` & `stall_i`: `hold_buf`<=`imem_rdata`; `if_out` holds; go HOLD.
  - !`imem_resp` & !`stall_i`: `if_out`<=bubble.
  - !`imem_resp` & `stall_i`: `if_out` holds.
- HOLD: `imem_read`=0.
  - `branch_take`: `pc`<=`branch_target`; `if_out`<=bubble; go RUN.
  - !`stall_i`: `if_out`<={`pc`, `hold_buf`, 1}; `pc`<=`pc`+4; go RUN.
  - Otherwise hold.
- DRAIN: `imem_read`=1, `imem_address`=`pc` (the stale address is kept until the cache responds). `if_out`<=bubble each cycle.
  - A new `branch_take` overwrites `pend_target`.
  - `imem_resp`: discard rdata; `pc`<=(`branch_take` ? `branch_target` : `pend_target`); go RUN.
- PC arithmetic: modulo 2^32; `pc`+4 from 32'hFFFF_FFFC wraps to 0. No alignment check; bits [1:0] pass through unchanged.
- Reset: `pc`=RESET_PC, `state`=RUN, `if_out`=bubble with `pc`=RESET_PC, `hold_buf`=0, `pend_target`=0. Reset during DRAIN or HOLD abandons the transaction; the I-cache is reset by the same `rst`.

## Timing
- `imem_read` and `imem_address` are combinational from `state`/`pc` only; no path from `imem_resp` or `stall_i`.
- Fetch latency: `if_out` valid on the edge following the `imem_resp` cycle.
- With a zero-wait cache (`imem_resp` in the request cycle), throughput is 1 instr/cycle.
- Redirect cost: 1 bubble if the cache is idle or responding; 1 + (remaining miss cycles) bubbles in DRAIN.
- `stall_i` during a miss does not stall the I-cache request; the response is buffered in HOLD.

## Configuration
- `I_FETCH_RVFI_EN` defined:
  - `if_out.rvfi_d.rvfi_pc_rdata` = fetched pc.
  - `rvfi_pc_wdata` = pc+4.
  - `rvfi_valid` = `valid`.
  - All other `rvfi_d` fields are 0 and are filled downstream.
- Not defined: `if_out.rvfi_d` is tied to '0 and no RVFI logic is synthesized. Functional behaviour is otherwise identical.

## Test plan
- Reset, zero-wait cache returning `pc`^32'hA5A5_0000 → `if_out.pc` = 4000_0000, 4000_0004, 4000_0008 on consecutive cycles, all valid=1.
- 3-cycle miss at 4000_0000 → 3 bubbles (`ir`=0000_0013, valid=0), then {4000_0000, data, 1}.
- `imem_resp` while `stall_i`=1 for 2 cycles → `imem_read`=0 during HOLD; `if_out` unchanged; the word appears the cycle after `stall_i` falls and `pc` becomes 4000_0004.
- `branch_take`, target 4000_0100, mid-miss at 4000_0008 → `imem_address` stays 4000_0008 until resp and that rdata never reaches `if_out`; next request is to 4000_0100; `if_out` is bubbles throughout.
- Second `branch_take` (target 4000_0200) during DRAIN, and `branch_take` + `stall_i` together in HOLD → the fetch goes to 4000_0200; the branch overrides the stall and `if_out` is a bubble.
- `pc`=FFFF_FFFC fetched → next `imem_address` = 0000_0000; with `I_FETCH_RVFI_EN`, `rvfi_pc_wdata` = 0000_0000.
